// File: rtl/fp_pkg.sv
// Shared types and default widths for the FP normaliser datapath.
// Defaults give IEEE single precision: 8-bit biased exponent, 23-bit stored fraction.
package fp_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MANT_W = 23;

  // All-ones exponent encodes Inf/NaN.
  localparam logic [DEF_EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  typedef struct packed {
    logic                  sign;
    logic [DEF_EXP_W-1:0]  exp;
    logic [DEF_MANT_W-1:0] frac;
  } fp_fields_t;

endpackage

// File: rtl/fp_norm_exp_step.sv
// Combinational exponent +1 / -1 with all-ones and <=1 detection.
// Both steps are formed one bit wider so wrap is visible to the flags.
module fp_norm_exp_step #(
  parameter int EXP_W = 8
) (
  input  logic [EXP_W-1:0] value,
  output logic [EXP_W-1:0] inc,
  output logic [EXP_W-1:0] dec,
  output logic             is_max,
  output logic             inc_max,
  output logic             le_one
);

  logic [EXP_W:0] sum_inc;
  logic [EXP_W:0] sum_dec;

  assign sum_inc = {1'b0, value} + (EXP_W+1)'(1);
  assign sum_dec = {1'b0, value} - (EXP_W+1)'(1);

  assign inc     = sum_inc[EXP_W-1:0];
  assign dec     = sum_dec[EXP_W-1:0];
  assign is_max  = (value == {EXP_W{1'b1}});
  assign inc_max = (sum_inc == {1'b0, {EXP_W{1'b1}}});
  // value<=1 means value-1 either borrowed (value==0) or landed on zero.
  assign le_one  = sum_dec[EXP_W] || (sum_dec[EXP_W-1:0] == '0);

endmodule

// File: rtl/fp_normalize_seq.sv
// Iterative post-add normaliser: one left shift per cycle until the hidden bit is set.
// Macro FP_NORM_DENORM_EN keeps underflowed results as subnormals instead of flushing to zero.
module fp_normalize_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_frac,
  output logic              out_zero,
  output logic              out_oflow,
  output logic              out_uflow,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready. in_ready is high
  // only in IDLE; out_valid rises on DONE entry and holds, with data stable, until out_ready.

  norm_state_t       state;
  logic              sign_r;
  logic [EXP_W-1:0]  exp_r;
  logic [MANT_W+1:0] mant_r;

  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  exp_dec;
  logic              exp_is_max;
  logic              exp_inc_max;
  logic              exp_le_one;

  logic              finish;
  logic [EXP_W-1:0]  nxt_exp;
  logic [MANT_W-1:0] nxt_frac;
  logic              nxt_zero;
  logic              nxt_oflow;
  logic              nxt_uflow;

  fp_norm_exp_step #(
    .EXP_W (EXP_W)
  ) u_exp_step (
    .value   (exp_r),
    .inc     (exp_inc),
    .dec     (exp_dec),
    .is_max  (exp_is_max),
    .inc_max (exp_inc_max),
    .le_one  (exp_le_one)
  );

  // Decision for the current SHIFT cycle; the first matching case wins.
  always_comb begin
    finish    = 1'b1;
    nxt_exp   = exp_r;
    nxt_frac  = mant_r[MANT_W-1:0];
    nxt_zero  = 1'b0;
    nxt_oflow = 1'b0;
    nxt_uflow = 1'b0;
    if (mant_r == '0) begin
      nxt_exp  = '0;
      nxt_frac = '0;
      nxt_zero = 1'b1;
    end else if (exp_is_max) begin
      // Inf/NaN from upstream passes straight through.
      nxt_exp  = exp_r;
    end else if (mant_r[MANT_W+1]) begin
      nxt_exp  = exp_inc;
      nxt_frac = mant_r[MANT_W:1];
      if (exp_inc_max) begin
        nxt_frac  = '0;
        nxt_oflow = 1'b1;
      end
    end else if (mant_r[MANT_W]) begin
      nxt_exp  = exp_r;
    end else if (exp_le_one) begin
`ifdef FP_NORM_DENORM_EN
      nxt_exp   = '0;
      nxt_frac  = mant_r[MANT_W-1:0];
      nxt_uflow = 1'b1;
      nxt_zero  = (mant_r[MANT_W-1:0] == '0);
`else
      nxt_exp   = '0;
      nxt_frac  = '0;
      nxt_zero  = 1'b1;
      nxt_uflow = 1'b1;
`endif
    end else begin
      finish = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_frac  <= '0;
      out_zero  <= 1'b0;
      out_oflow <= 1'b0;
      out_uflow <= 1'b0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      mant_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_r   <= in_sign;
            exp_r    <= in_exp;
            mant_r   <= in_mant;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (finish) begin
            out_sign  <= sign_r;
            out_exp   <= nxt_exp;
            out_frac  <= nxt_frac;
            out_zero  <= nxt_zero;
            out_oflow <= nxt_oflow;
            out_uflow <= nxt_uflow;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            mant_r <= {mant_r[MANT_W:0], 1'b0};
            exp_r  <= exp_dec;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Self-checking bench for fp_normalize_seq (EXP_W=8, MANT_W=23).
// Expected results go into a queue when an operand is driven and are popped when the result appears.
module tb_fp_normalize_seq;
  import fp_pkg::*;

  localparam int RW = 35;  // {sign, exp[7:0], frac[22:0], zero, oflow, uflow}

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero;
  logic        out_oflow;
  logic        out_uflow;
  logic [1:0]  dbg_state;

  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_cmp;
  int            n_bad;

  fp_normalize_seq #(.EXP_W(8), .MANT_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_oflow (out_oflow),
    .out_uflow (out_uflow),
    .dbg_state (dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] observed();
    return {out_sign, out_exp, out_frac, out_zero, out_oflow, out_uflow};
  endfunction

  // Reference normaliser written from the rule list, one loop per operand.
  function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                output logic [RW-1:0] res, output int lat);
    int          ee = int'(e);
    logic [24:0] mm = m;
    int          shifts = 0;
    logic        z = 1'b0;
    logic        o = 1'b0;
    logic        u = 1'b0;
    logic [22:0] f = m[22:0];
    if (m == 25'd0) begin
      ee = 0; f = '0; z = 1'b1;
    end else if (e == EXP_MAX) begin
      f = m[22:0];
    end else if (m[24]) begin
      ee = int'(e) + 1;
      f  = m[23:1];
      if (ee == 255) begin f = '0; o = 1'b1; end
    end else begin
      while (!mm[23] && ee > 1) begin
        mm = mm << 1; ee = ee - 1; shifts++;
      end
      if (mm[23]) begin
        f = mm[22:0];
      end else begin
`ifdef FP_NORM_DENORM_EN
        ee = 0; f = mm[22:0]; u = 1'b1; z = (mm[22:0] == 23'd0);
`else
        ee = 0; f = '0; z = 1'b1; u = 1'b1;
`endif
      end
    end
    res = {s, 8'(ee), f, z, o, u};
    lat = 2 + shifts;
  endfunction

  // ---- driver tasks ----
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  // Presents one operand and returns just after the accepting edge.
  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    while (!in_ready && guard < 100) begin
      @(negedge clk); guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_accept: in_ready stayed %0b, want 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency = clock edges from the accepting edge to the edge that can take the result.
  task automatic wait_valid(output int lat);
    lat = 1;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 60);
  endtask

  task automatic accept_out(output logic rdy_after, output logic vld_after);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rdy_after = in_ready;
    vld_after = out_valid;
  endtask

  // ---- tests ----
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (observed() !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", observed()); end
    n_cmp++;
    if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
  endtask

  localparam int NV = 10;
  localparam logic        T_SGN [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0]  T_EXP [NV] = '{8'h80, 8'h7F, 8'h85, 8'h45, 8'hFE, 8'h03, 8'hFF, 8'h80, 8'h01, 8'h01};
  localparam logic [24:0] T_MNT [NV] = '{25'h0800000, 25'h1800000, 25'h0000100, 25'h0000000, 25'h1000000,
                                         25'h0000001, 25'h0C00001, 25'h0000001, 25'h0400000, 25'h1000000};
  localparam int          T_LAT [NV] = '{2, 2, 17, 2, 2, 4, 2, 25, 2, 2};
`ifdef FP_NORM_DENORM_EN
  localparam logic [RW-1:0] T_RES5 = {1'b0, 8'h00, 23'h000004, 3'b001};
  localparam logic [RW-1:0] T_RES8 = {1'b0, 8'h00, 23'h400000, 3'b001};
`else
  localparam logic [RW-1:0] T_RES5 = {1'b0, 8'h00, 23'h000000, 3'b101};
  localparam logic [RW-1:0] T_RES8 = {1'b0, 8'h00, 23'h000000, 3'b101};
`endif
  localparam logic [RW-1:0] T_RES [NV] = '{
    {1'b0, 8'h80, 23'h000000, 3'b000},
    {1'b1, 8'h80, 23'h400000, 3'b000},
    {1'b0, 8'h76, 23'h000000, 3'b000},
    {1'b1, 8'h00, 23'h000000, 3'b100},
    {1'b0, 8'hFF, 23'h000000, 3'b010},
    T_RES5,
    {1'b0, 8'hFF, 23'h400001, 3'b000},
    {1'b0, 8'h69, 23'h000000, 3'b000},
    T_RES8,
    {1'b0, 8'h02, 23'h000000, 3'b000}
  };

  task automatic test_directed();
    int lat;
    logic rdy_a, vld_a;
    logic [RW-1:0] want;
    int want_lat;
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(T_RES[i]);
      lat_q.push_back(T_LAT[i]);
      send(T_SGN[i], T_EXP[i], T_MNT[i]);
      wait_valid(lat);
      want = exp_q.pop_front();
      want_lat = lat_q.pop_front();
      n_cmp++;
      if (!out_valid) begin
        n_bad++; $display("FAIL dir%0d_timeout: out_valid %b after %0d cycles, want 1", i, out_valid, lat);
      end else begin
        n_cmp++;
        if (observed() !== want) begin n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, observed(), want); end
        n_cmp++;
        if (lat !== want_lat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, want_lat); end
      end
      accept_out(rdy_a, vld_a);
      n_cmp++;
      if (rdy_a !== 1'b1 || vld_a !== 1'b0) begin
        n_bad++; $display("FAIL dir%0d_release: in_ready %b out_valid %b, want 1 0", i, rdy_a, vld_a);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic rdy_a, vld_a;
    logic [RW-1:0] want;
    exp_q.push_back({1'b1, 8'h80, 23'h400000, 3'b000});
    send(1'b1, 8'h7F, 25'h1800000);
    wait_valid(lat);
    want = exp_q.pop_front();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL hold%0d_handshake: out_valid %b in_ready %b, want 1 0", c, out_valid, in_ready);
      end
      n_cmp++;
      if (observed() !== want) begin n_bad++; $display("FAIL hold%0d_result: got %h want %h", c, observed(), want); end
    end
    accept_out(rdy_a, vld_a);
    n_cmp++;
    if (rdy_a !== 1'b1 || vld_a !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: in_ready %b out_valid %b, want 1 0", rdy_a, vld_a);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat;
    logic rdy_a, vld_a;
    logic [RW-1:0] want;
    send(1'b0, 8'h80, 25'h0000001);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_flags: in_ready %b out_valid %b, want 1 0", in_ready, out_valid);
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midrst_stale: out_valid seen %0d cycles, want 0", seen); end
    exp_q.push_back({1'b0, 8'h80, 23'h000000, 3'b000});
    send(1'b0, 8'h80, 25'h0800000);
    wait_valid(lat);
    want = exp_q.pop_front();
    n_cmp++;
    if (observed() !== want || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_next: got %h valid %b want %h valid 1", observed(), out_valid, want);
    end
    accept_out(rdy_a, vld_a);
  endtask

  task automatic test_random();
    int lat;
    int want_lat;
    int sh;
    logic rdy_a, vld_a;
    logic s;
    logic [7:0] e;
    logic [24:0] m;
    logic [RW-1:0] res;
    logic [RW-1:0] want;
    for (int i = 0; i < 24; i++) begin
      s  = 1'($urandom_range(0, 1));
      e  = (i % 3 == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      sh = $urandom_range(0, 25);
      m  = 25'($urandom()) >> sh;
      model(s, e, m, res, want_lat);
      exp_q.push_back(res);
      lat_q.push_back(want_lat);
      send(s, e, m);
      wait_valid(lat);
      want = exp_q.pop_front();
      want_lat = lat_q.pop_front();
      n_cmp++;
      if (observed() !== want || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rnd%0d_result: in e=%h m=%h got %h valid %b want %h", i, e, m, observed(), out_valid, want);
      end
      n_cmp++;
      if (lat !== want_lat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, want_lat); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      accept_out(rdy_a, vld_a);
    end
  endtask

  // ---- sequence and report ----
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
